// File: rtl/rf_pkg.sv
// Shared register-file widths and arbiter state encoding for the regfile
// access arbiter and its helpers.
package rf_pkg;
    localparam int RF_AW = 5;
    localparam int RF_DW = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// Round-robin priority search: the first set bit of req at or after ptr
// (wrapping modulo N) wins; grant is one-hot or zero.
module rr_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_arbiter.sv
// Shares the register-file access port between N requesters, with locking,
// lock timeout and a register-0 write guard. Define RFARB_FIXED_PRIO_EN to
// replace round-robin with lowest-index-wins in the unlocked state.
module regfile_arbiter
    import rf_pkg::*;
#(
    parameter int N        = 2,
    parameter int LOCK_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    input  logic [N-1:0]         req_we,
    input  logic [N-1:0]         req_lock,
    input  logic [RF_AW*N-1:0]   req_ra1,
    input  logic [RF_AW*N-1:0]   req_ra2,
    input  logic [RF_AW*N-1:0]   req_wa,
    input  logic [RF_DW*N-1:0]   req_din,
    output logic [N-1:0]         req_ready,
    output logic [N-1:0]         rsp_valid,
    output logic [RF_DW-1:0]     rsp_r1,
    output logic [RF_DW-1:0]     rsp_r2,
    output logic                 lock_timeout,
    output logic [RF_AW-1:0]     rf_ra1,
    output logic [RF_AW-1:0]     rf_ra2,
    output logic [RF_AW-1:0]     rf_wa,
    output logic [RF_DW-1:0]     rf_din,
    output logic                 rf_we,
    input  logic [RF_DW-1:0]     rf_r1,
    input  logic [RF_DW-1:0]     rf_r2,
    output arb_state_t           arb_state
);
    localparam int PW = $clog2(N);

    arb_state_t       state;
    logic [PW-1:0]    owner;
    logic [7:0]       lock_cnt;
    logic [N-1:0]     grant;
    logic [N-1:0]     pick_grant;
    logic [PW-1:0]    gidx;
    logic             accept;
    logic             owner_release;
    logic             timeout_hit;
    logic [RF_AW-1:0] g_ra1, g_ra2, g_wa;
    logic [RF_DW-1:0] g_din;
    logic [RF_AW-1:0] held_ra1, held_ra2, held_wa;
    logic [RF_DW-1:0] held_din;

`ifdef RFARB_FIXED_PRIO_EN
    localparam logic [PW-1:0] ZERO_PTR = '0;

    rr_picker #(.N(N)) u_picker (
        .req   (req_valid),
        .ptr   (ZERO_PTR),
        .grant (pick_grant)
    );
`else
    logic [PW-1:0] rr_ptr;

    rr_picker #(.N(N)) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant)
    );

    // Pointer only advances on unlocked acceptances, including the one that takes a lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (state == IDLE && accept) begin
            rr_ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
        end
    end
`endif

    // Grant is held at zero while reset is asserted so outputs match reset values.
    always_comb begin
        grant = '0;
        if (rst_n) begin
            if (state == IDLE) begin
                grant = pick_grant;
            end else if (req_valid[owner]) begin
                grant[owner] = 1'b1;
            end
        end
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                gidx = PW'(i);
            end
        end
    end

    assign accept = |grant;
    assign g_ra1  = req_ra1[int'(gidx)*RF_AW +: RF_AW];
    assign g_ra2  = req_ra2[int'(gidx)*RF_AW +: RF_AW];
    assign g_wa   = req_wa[int'(gidx)*RF_AW +: RF_AW];
    assign g_din  = req_din[int'(gidx)*RF_DW +: RF_DW];

    assign owner_release = (state == LOCKED) && accept && !req_lock[owner];
    assign timeout_hit   = (state == LOCKED) && (lock_cnt == 8'(LOCK_MAX - 1)) && !owner_release;

    assign req_ready    = grant;
    assign lock_timeout = timeout_hit;
    assign rf_ra1       = accept ? g_ra1 : held_ra1;
    assign rf_ra2       = accept ? g_ra2 : held_ra2;
    assign rf_wa        = accept ? g_wa  : held_wa;
    assign rf_din       = accept ? g_din : held_din;
    assign rf_we        = accept && req_we[gidx] && (g_wa != '0);
    assign rsp_r1       = rf_r1;
    assign rsp_r2       = rf_r2;
    assign arb_state    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            lock_cnt  <= '0;
            rsp_valid <= '0;
            held_ra1  <= '0;
            held_ra2  <= '0;
            held_wa   <= '0;
            held_din  <= '0;
        end else begin
            rsp_valid <= grant;
            if (accept) begin
                held_ra1 <= g_ra1;
                held_ra2 <= g_ra2;
                held_wa  <= g_wa;
                held_din <= g_din;
            end
            if (state == IDLE) begin
                if (accept && req_lock[gidx]) begin
                    state    <= LOCKED;
                    owner    <= gidx;
                    lock_cnt <= '0;
                end
            end else begin
                // A timeout wins over a lock request from the owner in the same cycle.
                if (owner_release || timeout_hit) begin
                    state    <= IDLE;
                    lock_cnt <= '0;
                end else begin
                    lock_cnt <= lock_cnt + 8'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios plus random traffic against a
// behavioural arbitration/register-file model with a response scoreboard.
module tb_regfile_arbiter;
    import rf_pkg::*;

    localparam int N        = 3;
    localparam int LOCK_MAX = 4;
    localparam int EW       = 104;

    logic                 clk;
    logic                 rst_n;
    logic [N-1:0]         req_valid, req_we, req_lock;
    logic [RF_AW*N-1:0]   req_ra1, req_ra2, req_wa;
    logic [RF_DW*N-1:0]   req_din;
    logic [N-1:0]         req_ready, rsp_valid;
    logic [RF_DW-1:0]     rsp_r1, rsp_r2;
    logic                 lock_timeout;
    logic [RF_AW-1:0]     rf_ra1, rf_ra2, rf_wa;
    logic [RF_DW-1:0]     rf_din;
    logic                 rf_we;
    logic [RF_DW-1:0]     rf_r1, rf_r2;
    arb_state_t           arb_state;

    logic        v[N], we[N], lk[N];
    logic [4:0]  a1[N], a2[N], wa[N];
    logic [31:0] din[N];

    logic [31:0] mem[32];
    logic [31:0] shadow[32];
    logic [EW-1:0] exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int m_locked = 0;
    int m_owner  = 0;
    int m_lc     = 0;
    int m_ptr    = 0;
    logic [4:0]  last_ra1 = '0, last_ra2 = '0, last_wa = '0;
    logic [31:0] last_din = '0;

    regfile_arbiter #(.N(N), .LOCK_MAX(LOCK_MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_lock     (req_lock),
        .req_ra1      (req_ra1),
        .req_ra2      (req_ra2),
        .req_wa       (req_wa),
        .req_din      (req_din),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_r1       (rsp_r1),
        .rsp_r2       (rsp_r2),
        .lock_timeout (lock_timeout),
        .rf_ra1       (rf_ra1),
        .rf_ra2       (rf_ra2),
        .rf_wa        (rf_wa),
        .rf_din       (rf_din),
        .rf_we        (rf_we),
        .rf_r1        (rf_r1),
        .rf_r2        (rf_r2),
        .arb_state    (arb_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        req_valid = '0; req_we = '0; req_lock = '0;
        req_ra1 = '0; req_ra2 = '0; req_wa = '0; req_din = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = v[i];
            req_we[i]          = we[i];
            req_lock[i]        = lk[i];
            req_ra1[i*5 +: 5]  = a1[i];
            req_ra2[i*5 +: 5]  = a2[i];
            req_wa[i*5 +: 5]   = wa[i];
            req_din[i*32 +: 32] = din[i];
        end
    end

    // Register file with registered reads (read-before-write)
    always @(posedge clk) begin
        rf_r1 <= mem[rf_ra1];
        rf_r2 <= mem[rf_ra2];
        if (rf_we) mem[rf_wa] <= rf_din;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver tasks
    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0; we[i] = 1'b0; lk[i] = 1'b0;
            a1[i] = '0; a2[i] = '0; wa[i] = '0; din[i] = '0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_reqs();
    endtask

    task automatic drive(input int i, input logic w, input logic l, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] wad, input logic [31:0] d);
        v[i] = 1'b1; we[i] = w; lk[i] = l;
        a1[i] = r1; a2[i] = r2; wa[i] = wad; din[i] = d;
    endtask

    // Reference model: decides the winner from the arbitration rules, predicts
    // port outputs, and queues the expected response.
    always @(negedge clk) begin
        int g;
        int j;
        logic rel;
        logic to;
        if (!rst_n) begin
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rf_we", 32'(rf_we), 32'd0);
            check("rst_lock_timeout", 32'(lock_timeout), 32'd0);
            check("rst_rf_ra1", 32'(rf_ra1), 32'd0);
            check("rst_rf_ra2", 32'(rf_ra2), 32'd0);
            check("rst_rf_wa", 32'(rf_wa), 32'd0);
            check("rst_rf_din", rf_din, 32'd0);
            check("rst_state", 32'(arb_state), 32'(IDLE));
            exp_q.delete();
            m_locked = 0; m_owner = 0; m_lc = 0; m_ptr = 0;
            last_ra1 = '0; last_ra2 = '0; last_wa = '0; last_din = '0;
        end else begin
            g = -1;
            if (m_locked != 0) begin
                if (v[m_owner]) g = m_owner;
            end else begin
`ifdef RFARB_FIXED_PRIO_EN
                for (int k = N - 1; k >= 0; k--) if (v[k]) g = k;
`else
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (g < 0 && v[j]) g = j;
                end
`endif
            end
            check("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
            rel = (m_locked != 0) && (g >= 0) && !lk[g];
            to  = (m_locked != 0) && (m_lc == LOCK_MAX) && !rel;
            check("lock_timeout", 32'(lock_timeout), 32'(to));
            if (g >= 0) begin
                last_ra1 = a1[g]; last_ra2 = a2[g]; last_wa = wa[g]; last_din = din[g];
                exp_q.push_back({32'(cyc), 8'(g), shadow[a1[g]], shadow[a2[g]]});
            end
            check("rf_ra1", 32'(rf_ra1), 32'(last_ra1));
            check("rf_ra2", 32'(rf_ra2), 32'(last_ra2));
            check("rf_wa", 32'(rf_wa), 32'(last_wa));
            check("rf_din", rf_din, last_din);
            check("rf_we", 32'(rf_we), 32'((g >= 0) && we[g] && (wa[g] != 5'd0)));
            if ((g >= 0) && we[g] && (wa[g] != 5'd0)) shadow[wa[g]] = din[g];
            if (m_locked == 0) begin
                if (g >= 0) begin
                    m_ptr = (g + 1) % N;
                    if (lk[g]) begin
                        m_locked = 1; m_owner = g; m_lc = 1;
                    end
                end
            end else if (rel || to) begin
                m_locked = 0; m_lc = 0;
            end else begin
                m_lc++;
            end
        end
    end

    // Monitor: pops the expectation queued for the previous cycle
    always @(negedge clk) begin
        logic [EW-1:0] e;
        #1;
        if (rst_n) begin
            if (exp_q.size() > 0 && exp_q[0][103:72] == 32'(cyc - 1)) begin
                e = exp_q.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'd1 << e[71:64]);
                check("rsp_r1", rsp_r1, e[63:32]);
                check("rsp_r2", rsp_r2, e[31:0]);
            end else begin
                check("rsp_idle", 32'(rsp_valid), 32'd0);
            end
        end
    end

    initial begin
        clear_reqs();
        for (int i = 0; i < 32; i++) begin
            mem[i]    = (i == 0) ? 32'd0 : $urandom;
            shadow[i] = mem[i];
        end
        rst_n = 1'b0;
        repeat (3) next_cycle();
        rst_n = 1'b1;

        // Round-robin between two readers
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            drive(0, 1'b0, 1'b0, 5'(1 + c), 5'(2 + c), 5'd0, 32'd0);
            drive(1, 1'b0, 1'b0, 5'(8 + c), 5'(9 + c), 5'd0, 32'd0);
        end

        // Register-0 write guard
        next_cycle(); drive(0, 1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 32'hDEADBEEF);
        next_cycle(); drive(0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);

        // Read-before-write on r5
        next_cycle(); drive(0, 1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 32'h12345678);
        next_cycle(); drive(0, 1'b0, 1'b0, 5'd5, 5'd6, 5'd0, 32'd0);

        // Lock held by requester 1, released explicitly
        next_cycle(); drive(1, 1'b0, 1'b1, 5'd7, 5'd8, 5'd0, 32'd0);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            drive(0, 1'b0, 1'b0, 5'd9, 5'd10, 5'd0, 32'd0);
            drive(1, 1'b1, (c < 2), 5'd11, 5'd12, 5'(20 + c), $urandom);
        end
        next_cycle(); drive(0, 1'b0, 1'b0, 5'd20, 5'd21, 5'd0, 32'd0);

        // Lock timeout with an idle owner
        next_cycle(); drive(1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0, 32'd0);
        for (int c = 0; c < 6; c++) begin
            next_cycle(); drive(0, 1'b0, 1'b0, 5'(c), 5'(c + 1), 5'd0, 32'd0);
        end

        // Reset while locked with a response outstanding
        next_cycle(); drive(1, 1'b0, 1'b1, 5'd3, 5'd4, 5'd0, 32'd0);
        next_cycle(); drive(1, 1'b0, 1'b1, 5'd5, 5'd6, 5'd0, 32'd0);
        rst_n = 1'b0;
        next_cycle();
        next_cycle(); rst_n = 1'b1;
        for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 5'(i + 1), 5'(i + 2), 5'd0, 32'd0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            next_cycle();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) < 6)
                    drive(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), $urandom);
            end
        end

        repeat (3) next_cycle();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
